// File: rtl/a2d_pots_spi_model.sv
// Behavioural SPI slave model of an 8-channel 12-bit A2D wired to the equalizer's six slide pots.
// Optional define MISO_TRISTATE_EN: MISO floats (1'bz) instead of driving 0 while slave select is high.
module a2d_pots_spi_model #(
   parameter int SYNC_STAGES = 2
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        SS_n,
   input  logic        SCLK,
   input  logic        MOSI,
   output logic        MISO,
   input  logic [11:0] LP,
   input  logic [11:0] B1,
   input  logic [11:0] B2,
   input  logic [11:0] B3,
   input  logic [11:0] HP,
   input  logic [11:0] VOL
);

   localparam int NS = (SYNC_STAGES < 2) ? 2 : SYNC_STAGES;

   logic [NS-1:0] ss_sync;
   logic [NS-1:0] sclk_sync;
   logic [NS-1:0] mosi_sync;
   logic          ss_d;
   logic          sclk_d;

   logic [2:0]    chan_reg;
   logic [15:0]   rx;
   logic [15:0]   tx_shift;
   logic [4:0]    bit_cnt;
   logic [11:0]   pot_sel;

   logic ss_s, sclk_s, mosi_s;
   logic ss_fall, ss_rise, sclk_rise, sclk_fall;

   // Idle levels preload the synchronizers so reset release never looks like an SPI edge.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         ss_sync   <= '1;
         sclk_sync <= '1;
         mosi_sync <= '0;
         ss_d      <= 1'b1;
         sclk_d    <= 1'b1;
      end else begin
         // NOTE: non-blocking assignments let every flop in the chain sample the old value of its neighbour.
         ss_sync   <= {ss_sync[NS-2:0], SS_n};
         sclk_sync <= {sclk_sync[NS-2:0], SCLK};
         mosi_sync <= {mosi_sync[NS-2:0], MOSI};
         ss_d      <= ss_sync[NS-1];
         sclk_d    <= sclk_sync[NS-1];
      end
   end

   assign ss_s      = ss_sync[NS-1];
   assign sclk_s    = sclk_sync[NS-1];
   assign mosi_s    = mosi_sync[NS-1];
   assign ss_fall   = ss_d & ~ss_s;
   assign ss_rise   = ~ss_d & ss_s;
   assign sclk_rise = ~sclk_d & sclk_s;
   assign sclk_fall = sclk_d & ~sclk_s;

   always_comb begin
      // NOTE: a default ahead of the case keeps unlisted channels from inferring a latch.
      pot_sel = 12'h000;
      case (chan_reg)
         3'd0:    pot_sel = B1;
         3'd1:    pot_sel = LP;
         3'd2:    pot_sel = B3;
         3'd3:    pot_sel = HP;
         3'd4:    pot_sel = B2;
         3'd7:    pot_sel = VOL;
         default: pot_sel = 12'h000;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         chan_reg <= 3'd0;
         rx       <= 16'h0000;
         tx_shift <= 16'h0000;
         bit_cnt  <= 5'd0;
      end else if (ss_s) begin
         bit_cnt <= 5'd0;
         // Only an exact 16-bit frame commits its command; short or long frames are dropped.
         if (ss_rise && bit_cnt == 5'd16)
            chan_reg <= rx[13:11];
      end else if (ss_fall) begin
         tx_shift <= {4'b0000, pot_sel};
      end else begin
         if (sclk_rise) begin
            rx <= {rx[14:0], mosi_s};
            // Saturate so a very long frame can never wrap back around to a count of 16.
            if (bit_cnt != 5'd31)
               bit_cnt <= bit_cnt + 5'd1;
         end
         if (sclk_fall && bit_cnt != 5'd0)
            tx_shift <= {tx_shift[14:0], 1'b0};
      end
   end

`ifdef MISO_TRISTATE_EN
   assign MISO = ss_s ? 1'bz : tx_shift[15];
`else
   assign MISO = ss_s ? 1'b0 : tx_shift[15];
`endif

endmodule

// File: tb/tb_a2d_pots_spi_model.sv
// Self-checking bench for a2d_pots_spi_model: directed scenarios plus random frames against a
// frame-level model (one-frame-delayed channel, pot snapshot at frame start).
module tb_a2d_pots_spi_model;

   localparam int HALF = 8;  // SCLK half period in clk cycles (SCLK = clk/16)

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   logic ss_n = 1'b1;
   logic sclk = 1'b1;
   logic mosi = 1'b0;
   logic miso;
   logic [11:0] lp = 12'h000, b1 = 12'h000, b2 = 12'h000;
   logic [11:0] b3 = 12'h000, hp = 12'h000, vol = 12'h000;

   int total = 0;
   int bad = 0;
   int model_ch = 0;

   always #5 clk = ~clk;

   a2d_pots_spi_model #(.SYNC_STAGES(2)) dut (
      .clk  (clk),
      .rst_n(rst_n),
      .SS_n (ss_n),
      .SCLK (sclk),
      .MOSI (mosi),
      .MISO (miso),
      .LP   (lp),
      .B1   (b1),
      .B2   (b2),
      .B3   (b3),
      .HP   (hp),
      .VOL  (vol)
   );

   // Channel table as wired on the board: index = channel number.
   function automatic logic [11:0] pot_value(input int ch);
      logic [11:0] tbl [8];
      tbl = '{b1, lp, b3, hp, b2, 12'h000, 12'h000, vol};
      return tbl[ch];
   endfunction

   function automatic logic [15:0] cmd_for(input int ch);
      logic [15:0] c;
      c = 16'h0000;
      c[13:11] = ch[2:0];
      return c;
   endfunction

   task automatic wait_clks(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   // Runs one frame of nbits SCLK cycles; returns what was read and what the model predicts.
   task automatic run_frame(input logic [15:0] cmd, input int nbits,
                            output logic [15:0] rd, output logic [15:0] exp);
      exp = {4'h0, pot_value(model_ch)};
      rd  = 16'h0000;
      ss_n = 1'b0;
      wait_clks(HALF);
      for (int i = 0; i < nbits; i++) begin
         sclk = 1'b0;
         mosi = (i < 16) ? cmd[15-i] : 1'b0;
         wait_clks(HALF);
         rd = {rd[14:0], miso};
         sclk = 1'b1;
         wait_clks(HALF);
      end
      ss_n = 1'b1;
      wait_clks(2 * HALF);
      if (nbits == 16)
         model_ch = int'(cmd[13:11]);
   endtask

   task automatic test_reset;
      rst_n = 1'b0;
      wait_clks(3);
      total++;
      if (miso !== 1'b0) begin
         bad++;
         $display("FAIL reset_miso: got %b want 0", miso);
      end
      rst_n = 1'b1;
      wait_clks(6);
      total++;
      if (miso !== 1'b0) begin
         bad++;
         $display("FAIL idle_miso: got %b want 0", miso);
      end
      model_ch = 0;
   endtask

   task automatic test_first_frame;
      logic [15:0] rd, exp;
      b1 = 12'hABC;
      lp = 12'h123;
      run_frame(16'h0800, 16, rd, exp);
      total++;
      if (rd !== 16'h0ABC || rd !== exp) begin
         bad++;
         $display("FAIL first_frame: got %h want 0abc", rd);
      end
      run_frame(16'hC7FF & 16'hC7FF, 16, rd, exp);
      total++;
      if (rd !== 16'h0123) begin
         bad++;
         $display("FAIL second_frame_lp: got %h want 0123", rd);
      end
   endtask

   task automatic test_channel_cycle;
      logic [15:0] rd, exp;
      int seq [7] = '{1, 0, 4, 2, 3, 7, 1};
      lp = 12'h080; b1 = 12'h081; b2 = 12'h082;
      b3 = 12'h083; hp = 12'h084; vol = 12'hFFF;
      run_frame(cmd_for(seq[0]), 16, rd, exp);
      for (int i = 1; i < 7; i++) begin
         run_frame(cmd_for(seq[i]), 16, rd, exp);
         total++;
         if (rd !== exp) begin
            bad++;
            $display("FAIL chan_cycle ch%0d: got %h want %h", seq[i-1], rd, exp);
         end
      end
      // The frame after the ch7 command (i == 6) returned VOL; check its literal value too.
      run_frame(cmd_for(7), 16, rd, exp);
      run_frame(cmd_for(0), 16, rd, exp);
      total++;
      if (rd !== 16'h0FFF) begin
         bad++;
         $display("FAIL vol_frame: got %h want 0fff", rd);
      end
   endtask

   task automatic test_unused_channels;
      logic [15:0] rd, exp;
      run_frame(cmd_for(5), 16, rd, exp);
      run_frame(cmd_for(6), 16, rd, exp);
      total++;
      if (rd !== 16'h0000) begin
         bad++;
         $display("FAIL ch5_zero: got %h want 0000", rd);
      end
      run_frame(cmd_for(0), 16, rd, exp);
      total++;
      if (rd !== 16'h0000) begin
         bad++;
         $display("FAIL ch6_zero: got %h want 0000", rd);
      end
   endtask

   task automatic test_partial_frame;
      logic [15:0] rd, exp;
      hp = 12'h5A3;
      vol = 12'hFFF;
      run_frame(cmd_for(3), 16, rd, exp);
      run_frame(cmd_for(7), 9, rd, exp);
      run_frame(cmd_for(1), 16, rd, exp);
      total++;
      if (rd !== 16'h05A3 || rd !== exp) begin
         bad++;
         $display("FAIL partial_discard: got %h want 05a3", rd);
      end
      // Overlong frame (17 clocks) carrying ch7 is dropped as well; LP from previous frame stays.
      lp = 12'h3C1;
      run_frame(cmd_for(7), 17, rd, exp);
      run_frame(cmd_for(0), 16, rd, exp);
      total++;
      if (rd !== 16'h03C1) begin
         bad++;
         $display("FAIL overlong_discard: got %h want 03c1", rd);
      end
   endtask

   task automatic test_snapshot;
      logic [15:0] rd, exp;
      run_frame(cmd_for(4), 16, rd, exp);
      b2 = 12'h800;
      fork
         run_frame(cmd_for(4), 16, rd, exp);
         begin
            wait_clks(HALF * 9);
            b2 = 12'h080;
         end
      join
      total++;
      if (rd !== 16'h0800) begin
         bad++;
         $display("FAIL snapshot_old: got %h want 0800", rd);
      end
      run_frame(cmd_for(4), 16, rd, exp);
      total++;
      if (rd !== 16'h0080) begin
         bad++;
         $display("FAIL snapshot_new: got %h want 0080", rd);
      end
   endtask

   task automatic test_reset_mid_frame;
      logic [15:0] rd, exp;
      vol = 12'hFFF;
      run_frame(cmd_for(7), 16, rd, exp);
      ss_n = 1'b0;
      wait_clks(HALF);
      for (int i = 0; i < 6; i++) begin
         sclk = 1'b0;
         mosi = 1'b1;
         wait_clks(HALF);
         sclk = 1'b1;
         wait_clks(HALF);
      end
      total++;
      if (miso !== 1'b1) begin
         bad++;
         $display("FAIL midframe_vol_bit: got %b want 1", miso);
      end
      rst_n = 1'b0;
      #1;
      total++;
      if (miso !== 1'b0) begin
         bad++;
         $display("FAIL midframe_reset_miso: got %b want 0", miso);
      end
      ss_n = 1'b1;
      sclk = 1'b1;
      mosi = 1'b0;
      wait_clks(4);
      rst_n = 1'b1;
      wait_clks(4);
      model_ch = 0;
      b1 = 12'h6D5;
      run_frame(cmd_for(2), 16, rd, exp);
      total++;
      if (rd !== 16'h06D5) begin
         bad++;
         $display("FAIL after_reset_b1: got %h want 06d5", rd);
      end
   endtask

   task automatic test_random;
      logic [15:0] rd, exp, cmd;
      int nbits;
      for (int n = 0; n < 30; n++) begin
         lp = 12'($urandom); b1 = 12'($urandom); b2 = 12'($urandom);
         b3 = 12'($urandom); hp = 12'($urandom); vol = 12'($urandom);
         cmd = 16'($urandom);
         case ($urandom_range(0, 7))
            0:       nbits = 9;
            1:       nbits = 17;
            default: nbits = 16;
         endcase
         run_frame(cmd, nbits, rd, exp);
         if (nbits == 16) begin
            total++;
            if (rd !== exp) begin
               bad++;
               $display("FAIL random_frame %0d: got %h want %h", n, rd, exp);
            end
         end
      end
   endtask

   initial begin
      test_reset();
      test_first_frame();
      test_channel_cycle();
      test_unused_channels();
      test_partial_frame();
      test_snapshot();
      test_reset_mid_frame();
      test_random();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
